// File: rtl/pcileech_tlp_tx_packer_if.sv
// Bundles the DWORD-serial TLP input and the AXI-stream beat output of the
// TLP transmit packer. The master modport is the packer's own view, because it
// drives the AXI-stream. The slave modport is the environment's view: it feeds
// DWORDs in and sinks beats.
interface pcileech_tlp_tx_packer_if #(
  parameter int DW_PER_BEAT = 2
);
  logic [31:0]               tx_data;
  logic                      tx_last;
  logic                      tx_valid;
  logic [32*DW_PER_BEAT-1:0] m_tdata;
  logic [4*DW_PER_BEAT-1:0]  m_tkeep;
  logic                      m_tlast;
  logic                      m_tvalid;
  logic                      m_tready;

  modport master (
    input  tx_data, tx_last, tx_valid, m_tready,
    output m_tdata, m_tkeep, m_tlast, m_tvalid
  );

  modport slave (
    output tx_data, tx_last, tx_valid, m_tready,
    input  m_tdata, m_tkeep, m_tlast, m_tvalid
  );
endinterface

// File: rtl/pcileech_tlp_tx_packer.sv
// Packs a DWORD-serial TLP stream into DW_PER_BEAT-wide beats. Whole TLPs are
// buffered store-and-forward and then presented on an AXI-stream master.
// TLPs that overflow the buffer or exceed MAX_TLP_DW are rewound and counted,
// so the output only ever sees complete TLPs.
module pcileech_tlp_tx_packer #(
  parameter int DW_PER_BEAT = 2,
  parameter int DEPTH       = 512,
  parameter int MAX_TLP_DW  = 132
) (
  input  logic                      clk_100,
  input  logic                      rst,
  pcileech_tlp_tx_packer_if.master  bus,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(DW_PER_BEAT);
  localparam int CW = $clog2(MAX_TLP_DW + 2);   // holds MAX_TLP_DW+1 without wrapping
  localparam int DB = 32 * DW_PER_BEAT;
  localparam int KB = 4 * DW_PER_BEAT;

  typedef logic [AW:0] ptr_t;                   // extra MSB is the wrap bit
  typedef struct packed {
    logic          last;
    logic [KB-1:0] keep;
    logic [DB-1:0] data;
  } beat_t;

  // Packer state
  logic [IW-1:0]                   idx_q, idx_d;
  logic [DW_PER_BEAT-1:0][31:0]    lanes_q, lanes_d;
  logic [CW-1:0]                   dwc_q, dwc_d;
  logic                            drop_q, drop_d;
  logic [15:0]                     drop_cnt_q, drop_cnt_d;

  // Buffer state
  beat_t                           mem [DEPTH];
  ptr_t                            wr_ptr_q, wr_ptr_d;
  ptr_t                            cm_ptr_q, cm_ptr_d;
  ptr_t                            rd_ptr_q, rd_ptr_d;

  // Output stage
  beat_t                           out_q, out_d;
  logic                            out_valid_q, out_valid_d;

  // Combinational helpers
  logic [CW-1:0]                   dwc_inc;
  logic                            emit;
  logic                            full;
  logic                            wr_en;
  beat_t                           wr_beat;
  logic                            load;

  // Packer and write side: lane packing, beat emit, commit and drop/rewind.
  // NOTE: every signal gets its default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    idx_d      = idx_q;
    lanes_d    = lanes_q;
    dwc_d      = dwc_q;
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    wr_en      = 1'b0;
    wr_beat    = '0;
    dwc_inc    = (dwc_q == CW'(MAX_TLP_DW + 1)) ? dwc_q : dwc_q + 1'b1;
    emit       = (idx_q == IW'(DW_PER_BEAT - 1)) || bus.tx_last;
    // The full check deliberately uses rd_ptr before any same-cycle read.
    full       = (wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);

    // Lanes below idx come from the beat register, lane idx is the incoming
    // DWORD, and lanes above stay zero with keep cleared.
    for (int j = 0; j < DW_PER_BEAT; j++) begin
      if (j < int'(idx_q)) begin
        wr_beat.data[j*32 +: 32] = lanes_q[j];
        wr_beat.keep[j*4 +: 4]   = 4'hF;
      end else if (j == int'(idx_q)) begin
        wr_beat.data[j*32 +: 32] = bus.tx_data;
        wr_beat.keep[j*4 +: 4]   = 4'hF;
      end
    end
    wr_beat.last = bus.tx_last;

    if (bus.tx_valid) begin
      if (drop_q || (dwc_inc > CW'(MAX_TLP_DW)) || (emit && full)) begin
        // Discarding: keep tracking lanes only to find tx_last, then rewind
        // the speculative writes of this TLP back to the last commit.
        if (bus.tx_last) begin
          wr_ptr_d   = cm_ptr_q;
          drop_d     = 1'b0;
          drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
          idx_d      = '0;
          dwc_d      = '0;
        end else begin
          drop_d = 1'b1;
          dwc_d  = dwc_inc;
          idx_d  = emit ? '0 : idx_q + 1'b1;
        end
      end else begin
        lanes_d[idx_q] = bus.tx_data;
        dwc_d          = dwc_inc;
        idx_d          = idx_q + 1'b1;
        if (emit) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          idx_d    = '0;
          if (bus.tx_last) begin
            cm_ptr_d = wr_ptr_q + 1'b1;
            dwc_d    = '0;
          end
        end
      end
    end
  end

  // Read side: refill the output stage from committed beats only.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    load        = (rd_ptr_q != cm_ptr_q) && (!out_valid_q || bus.m_tready);
    if (load) begin
      out_d       = mem[rd_ptr_q[AW-1:0]];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end else if (bus.m_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // Beat storage.
  // NOTE: the array has no reset. Only the pointers define which entries are
  // live, so it can map onto block RAM.
  always_ff @(posedge clk_100) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_beat;
  end

  // State registers with synchronous reset. A reset discards any partial TLP.
  // NOTE: non-blocking assignments give every register the same sampled view
  // of the previous cycle.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      idx_q       <= '0;
      lanes_q     <= '0;
      dwc_q       <= '0;
      drop_q      <= 1'b0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      lanes_q     <= lanes_d;
      dwc_q       <= dwc_d;
      drop_q      <= drop_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.m_tdata  = out_q.data;
  assign bus.m_tkeep  = out_q.keep;
  assign bus.m_tlast  = out_q.last;
  assign bus.m_tvalid = out_valid_q;
  // The beat in the output stage counts as unread until the sink accepts it.
  assign level        = (wr_ptr_q - rd_ptr_q) + ptr_t'(out_valid_q);
  assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_pcileech_tlp_tx_packer.sv
// Directed and random checks of the TLP transmit packer using two instances:
// A (2 DW/beat, 8-beat buffer, 8-DW limit) and B (4 DW/beat, 512 beats, 132 DW).
// Expected beats are queued when DWORDs are driven, and popped on each transfer.
module tb_pcileech_tlp_tx_packer;
  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic        clk_100;
  logic        rst;
  logic [3:0]  level_a;
  logic [15:0] drop_cnt_a;
  logic [9:0]  level_b;
  logic [15:0] drop_cnt_b;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          xfer_a  = 0;
  int          xfer_b  = 0;
  int          mark;
  bit          rnd_rdy_b = 0;
  bit          hold_a = 0, hold_b = 0;
  beat_t       held_a, held_b;
  beat_t       exp_a[$];
  beat_t       exp_b[$];

  pcileech_tlp_tx_packer_if #(.DW_PER_BEAT(2)) bus_a ();
  pcileech_tlp_tx_packer_if #(.DW_PER_BEAT(4)) bus_b ();

  pcileech_tlp_tx_packer #(.DW_PER_BEAT(2), .DEPTH(8), .MAX_TLP_DW(8)) dut_a (
    .clk_100(clk_100), .rst(rst), .bus(bus_a), .level(level_a), .drop_cnt(drop_cnt_a)
  );
  pcileech_tlp_tx_packer #(.DW_PER_BEAT(4), .DEPTH(512), .MAX_TLP_DW(132)) dut_b (
    .clk_100(clk_100), .rst(rst), .bus(bus_b), .level(level_b), .drop_cnt(drop_cnt_b)
  );

  initial begin
    clk_100 = 1'b0;
    forever #5 clk_100 = ~clk_100;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples both outputs on the falling edge: transfers, and stability under stall.
  task automatic monitor();
    beat_t cur, e;
    if (rst) begin
      hold_a = 0;
      hold_b = 0;
      return;
    end
    cur = '{data: {64'h0, bus_a.m_tdata}, keep: {8'h0, bus_a.m_tkeep}, last: bus_a.m_tlast};
    if (hold_a) begin
      check("a_stall_valid", bus_a.m_tvalid, 1);
      check("a_stall_data", cur.data, held_a.data);
      check("a_stall_ctl", {cur.keep, cur.last}, {held_a.keep, held_a.last});
    end
    hold_a = bus_a.m_tvalid && !bus_a.m_tready;
    held_a = cur;
    if (bus_a.m_tvalid && bus_a.m_tready) begin
      check("a_beat_expected", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        check("a_data", cur.data, e.data);
        check("a_keep", cur.keep, e.keep);
        check("a_last", cur.last, e.last);
        xfer_a++;
      end
    end

    cur = '{data: bus_b.m_tdata, keep: bus_b.m_tkeep, last: bus_b.m_tlast};
    if (hold_b) begin
      check("b_stall_valid", bus_b.m_tvalid, 1);
      check("b_stall_data", cur.data, held_b.data);
      check("b_stall_ctl", {cur.keep, cur.last}, {held_b.keep, held_b.last});
    end
    hold_b = bus_b.m_tvalid && !bus_b.m_tready;
    held_b = cur;
    if (bus_b.m_tvalid && bus_b.m_tready) begin
      check("b_beat_expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        check("b_data", cur.data, e.data);
        check("b_keep", cur.keep, e.keep);
        check("b_last", cur.last, e.last);
        xfer_b++;
      end
    end
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit after the rise.
  task automatic tick();
    @(negedge clk_100);
    monitor();
    @(posedge clk_100);
    #1;
    if (rnd_rdy_b) bus_b.m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_dw(input int inst, input logic [31:0] dw, input logic last);
    if (inst == 0) begin
      bus_a.tx_data = dw; bus_a.tx_last = last; bus_a.tx_valid = 1'b1;
    end else begin
      bus_b.tx_data = dw; bus_b.tx_last = last; bus_b.tx_valid = 1'b1;
    end
    tick();
    bus_a.tx_valid = 1'b0; bus_a.tx_last = 1'b0;
    bus_b.tx_valid = 1'b0; bus_b.tx_last = 1'b0;
  endtask

  // Drives a TLP and, if it should survive, queues its packed beats.
  task automatic send_tlp(input int inst, input int len, input bit keep_it,
                          input logic [31:0] base, input bit rnd);
    int          n;
    int          lane;
    beat_t       cur;
    logic [31:0] dw;
    n   = (inst == 0) ? 2 : 4;
    cur = '0;
    for (int i = 0; i < len; i++) begin
      dw   = rnd ? $urandom : base + 32'(i);
      lane = i % n;
      cur.data[lane*32 +: 32] = dw;
      cur.keep[lane*4 +: 4]   = 4'hF;
      if (lane == n - 1 || i == len - 1) begin
        cur.last = (i == len - 1);
        if (keep_it) begin
          if (inst == 0) exp_a.push_back(cur);
          else           exp_b.push_back(cur);
        end
        cur = '0;
      end
      drive_dw(inst, dw, i == len - 1);
      if (rnd && $urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic drain(input int inst, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((inst == 0 ? exp_a.size() : exp_b.size()) == 0) break;
      tick();
    end
    tick();
    tick();
    check(inst == 0 ? "a_drain" : "b_drain", inst == 0 ? exp_a.size() : exp_b.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.tx_data = '0; bus_a.tx_last = 1'b0; bus_a.tx_valid = 1'b0; bus_a.m_tready = 1'b1;
    bus_b.tx_data = '0; bus_b.tx_last = 1'b0; bus_b.tx_valid = 1'b0; bus_b.m_tready = 1'b1;
    tick();
    tick();
    check("rst_a_tvalid", bus_a.m_tvalid, 0);
    check("rst_a_tlast", bus_a.m_tlast, 0);
    check("rst_a_tkeep", bus_a.m_tkeep, 0);
    check("rst_a_tdata", bus_a.m_tdata, 0);
    check("rst_a_level", level_a, 0);
    check("rst_a_drop", drop_cnt_a, 0);
    check("rst_b_tvalid", bus_b.m_tvalid, 0);
    check("rst_b_level", level_b, 0);
    rst = 1'b0;
    tick();

    // 3-DW TLP at 2 DW/beat: store-and-forward latency and partial last beat.
    send_tlp(0, 3, 1, 32'hA000_0001, 0);
    check("t1_not_before_e1", bus_a.m_tvalid, 0);
    tick();
    check("t1_b0_valid", bus_a.m_tvalid, 1);
    check("t1_b0_data", bus_a.m_tdata, {32'hA000_0002, 32'hA000_0001});
    check("t1_b0_keep", bus_a.m_tkeep, 8'hFF);
    check("t1_b0_last", bus_a.m_tlast, 0);
    tick();
    check("t1_b1_valid", bus_a.m_tvalid, 1);
    check("t1_b1_data", bus_a.m_tdata, {32'h0, 32'hA000_0003});
    check("t1_b1_keep", bus_a.m_tkeep, 8'h0F);
    check("t1_b1_last", bus_a.m_tlast, 1);
    drain(0, 20);

    // Full buffer with stalled sink: the fifth TLP is dropped whole.
    do_reset();
    bus_a.m_tready = 1'b0;
    for (int t = 0; t < 4; t++) send_tlp(0, 4, 1, 32'h3000_0000 + 32'(t * 16), 0);
    tick();
    tick();
    check("t3_level_full", level_a, 8);
    check("t3_no_drop_yet", drop_cnt_a, 0);
    send_tlp(0, 4, 0, 32'h3F00_0000, 0);
    tick();
    check("t3_drop_cnt", drop_cnt_a, 1);
    check("t3_level_kept", level_a, 8);
    check("t3_held_valid", bus_a.m_tvalid, 1);
    mark = xfer_a;
    bus_a.m_tready = 1'b1;
    drain(0, 40);
    check("t3_beats_out", xfer_a - mark, 8);

    // Over-length TLP dropped without emitting anything; the next one passes.
    do_reset();
    mark = xfer_a;
    send_tlp(0, 10, 0, 32'h4000_0000, 0);
    send_tlp(0, 2, 1, 32'h4100_0000, 0);
    drain(0, 20);
    check("t4_drop_cnt", drop_cnt_a, 1);
    check("t4_beats_out", xfer_a - mark, 1);

    // Reset in the middle of a TLP discards it and clears the drop counter.
    drive_dw(0, 32'h5000_0000, 0);
    drive_dw(0, 32'h5000_0001, 0);
    drive_dw(0, 32'h5000_0002, 0);
    rst = 1'b1;
    tick();
    check("t6_tvalid", bus_a.m_tvalid, 0);
    check("t6_tlast", bus_a.m_tlast, 0);
    check("t6_tkeep", bus_a.m_tkeep, 0);
    check("t6_tdata", bus_a.m_tdata, 0);
    check("t6_level", level_a, 0);
    check("t6_drop_cnt", drop_cnt_a, 0);
    tick();
    rst = 1'b0;
    mark = xfer_a;
    send_tlp(0, 2, 1, 32'h5100_0000, 0);
    drain(0, 20);
    check("t6_beats_out", xfer_a - mark, 1);
    check("t6_drop_after", drop_cnt_a, 0);

    // 4 DW/beat: full-beat TLP back-to-back with a 1-DW TLP, no output gap.
    send_tlp(1, 4, 1, 32'hB000_0000, 0);
    check("t2_not_before_e1", bus_b.m_tvalid, 0);
    send_tlp(1, 1, 1, 32'hB100_0000, 0);
    check("t2_b0_valid", bus_b.m_tvalid, 1);
    check("t2_b0_keep", bus_b.m_tkeep, 16'hFFFF);
    check("t2_b0_last", bus_b.m_tlast, 1);
    tick();
    check("t2_b1_valid", bus_b.m_tvalid, 1);
    check("t2_b1_keep", bus_b.m_tkeep, 16'h000F);
    check("t2_b1_last", bus_b.m_tlast, 1);
    tick();
    check("t2_idle", bus_b.m_tvalid, 0);
    drain(1, 20);

    // Random-length stream with a randomly stalling sink.
    rnd_rdy_b = 1;
    for (int t = 0; t < 200; t++) send_tlp(1, $urandom_range(1, 20), 1, 32'h0, 1);
    drain(1, 5000);
    rnd_rdy_b = 0;
    bus_b.m_tready = 1'b1;
    check("t5_drop_cnt", drop_cnt_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
